// File: rtl/cnn_pkg.sv
// Shared types and default sizing for the kernel-pass sequencer.
// Imported by the interface and the sequencer RTL.
package cnn_pkg;

    localparam int MAX_KERNELS_DEF     = 64;
    localparam int MAX_OUTSTANDING_DEF = 2;
    localparam int ACK_TIMEOUT_DEF     = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_GAP,
        S_DRAIN
    } seq_state_e;

endpackage

// File: rtl/cnn_kernel_seq_if.sv
// Controller/core bundle of the kernel-pass sequencer.
// master = controller + core side, slave = the sequencer.
interface cnn_kernel_seq_if
    import cnn_pkg::*;
#(
    parameter int KIDX_W = $clog2(MAX_KERNELS_DEF),
    parameter int CNT_W  = KIDX_W + 1
);
    logic              start;
    logic [CNT_W-1:0]  cfg_num_kernels;
    logic [KIDX_W-1:0] cfg_kernel_base;
    logic              abort;
    logic              idle;
    logic              done;
    logic              aborted;
    logic              err;
    logic [CNT_W-1:0]  finished_count;
    logic              core_start;
    logic [KIDX_W-1:0] core_kernel_idx;
    logic              core_idle;
    logic              core_finish;

    modport master (
        output start,
        output cfg_num_kernels,
        output cfg_kernel_base,
        output abort,
        output core_idle,
        output core_finish,
        input  idle,
        input  done,
        input  aborted,
        input  err,
        input  finished_count,
        input  core_start,
        input  core_kernel_idx
    );

    modport slave (
        input  start,
        input  cfg_num_kernels,
        input  cfg_kernel_base,
        input  abort,
        input  core_idle,
        input  core_finish,
        output idle,
        output done,
        output aborted,
        output err,
        output finished_count,
        output core_start,
        output core_kernel_idx
    );

endinterface

// File: rtl/cnn_ack_watchdog.sv
// Ack watchdog: reloads on every issue, counts down while waiting for
// the core to leave idle; o_expired marks the last permitted wait cycle.
module cnn_ack_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/cnn_kernel_seq.sv
// Kernel-pass sequencer: issues a run of passes to the single-pass
// convolution core with bounded overlap, abort and ack watchdog.
module cnn_kernel_seq
    import cnn_pkg::*;
#(
    parameter int MAX_KERNELS     = MAX_KERNELS_DEF,
    parameter int KIDX_W          = $clog2(MAX_KERNELS),
    parameter int CNT_W           = KIDX_W + 1,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int ACK_TIMEOUT     = ACK_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    cnn_kernel_seq_if.slave bus
);
    localparam logic [CNT_W-1:0] NUM_MAX = CNT_W'(MAX_KERNELS);
    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUTSTANDING);

    seq_state_e        r_state;
    seq_state_e        w_next;

    logic [CNT_W-1:0]  r_num;
    logic [KIDX_W-1:0] r_base;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_finished;
    logic [KIDX_W-1:0] r_kidx;
    logic              r_idle;
    logic              r_cs;
    logic              r_done;
    logic              r_err;
    logic              r_aborted;
    logic              r_to;

    logic              w_cfg_ok;
    logic              w_accept;
    logic              w_reject;
    logic [CNT_W-1:0]  w_outstanding;
    logic              w_fin_ok;
    logic              w_fin_bad;
    logic [CNT_W-1:0]  w_fin_next;
    logic              w_expired;
    logic              w_abort_hit;
    logic              w_timeout;
    logic              w_issue;
    logic              w_run_end;

    cnn_ack_watchdog #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_state == S_ISSUE),
        .i_en      (r_state == S_ACK),
        .o_expired (w_expired)
    );

    assign w_cfg_ok = (bus.cfg_num_kernels != '0)
                   && (bus.cfg_num_kernels <= NUM_MAX);
    assign w_accept = (r_state == S_IDLE) && bus.start && w_cfg_ok;
    assign w_reject = (r_state == S_IDLE) && bus.start && !w_cfg_ok;

    // A finish with nothing in flight (or while idle) is a core fault.
    assign w_outstanding = r_issued - r_finished;
    assign w_fin_ok   = bus.core_finish && (r_state != S_IDLE)
                     && (w_outstanding != '0);
    assign w_fin_bad  = bus.core_finish && !w_fin_ok;
    assign w_fin_next = w_fin_ok ? (r_finished + 1'b1) : r_finished;

    always_comb begin
        w_next      = r_state;
        w_abort_hit = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_ACK;
            end
            S_ACK: begin
                if (!bus.core_idle) begin
                    if (r_issued == r_num) begin
                        w_next = S_DRAIN;
                    end else if (bus.abort) begin
                        w_next      = S_DRAIN;
                        w_abort_hit = 1'b1;
                    end else begin
                        w_next = S_GAP;
                    end
                end else if (w_expired) begin
                    w_next    = S_DRAIN;
                    w_timeout = 1'b1;
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    w_next      = S_DRAIN;
                    w_abort_hit = 1'b1;
                end else if (bus.core_idle
                          && (w_outstanding < OUT_MAX)) begin
                    w_next = S_ISSUE;
                end
            end
            S_DRAIN: begin
                // An unacked pass never finishes, so a timeout ends at once.
                if (r_to || (w_fin_next == r_issued)) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_issue   = (w_next == S_ISSUE);
    assign w_run_end = (r_state == S_DRAIN) && (w_next == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idle  <= 1'b1;
            r_cs    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idle  <= (w_next == S_IDLE);
            r_cs    <= w_issue;
            r_done  <= w_reject || w_run_end;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
            r_to      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_err     <= 1'b0;
                r_aborted <= 1'b0;
                r_to      <= 1'b0;
            end
            if (w_reject) begin
                r_err     <= 1'b1;
                r_aborted <= 1'b1;
            end
            if (w_abort_hit) begin
                r_aborted <= 1'b1;
            end
            if (w_timeout) begin
                r_err     <= 1'b1;
                r_aborted <= 1'b1;
                r_to      <= 1'b1;
            end
            if (w_fin_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // r_issued counts the pass being issued, so outstanding covers it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num      <= '0;
            r_base     <= '0;
            r_issued   <= '0;
            r_finished <= '0;
            r_kidx     <= '0;
        end else begin
            if (w_accept) begin
                r_num      <= bus.cfg_num_kernels;
                r_base     <= bus.cfg_kernel_base;
                r_finished <= '0;
            end else if (w_fin_ok) begin
                r_finished <= r_finished + 1'b1;
            end
            if (w_issue) begin
                if (w_accept) begin
                    r_issued <= CNT_W'(1);
                    r_kidx   <= bus.cfg_kernel_base;
                end else begin
                    r_issued <= r_issued + 1'b1;
                    r_kidx   <= r_base + r_issued[KIDX_W-1:0];
                end
            end
        end
    end

    assign bus.idle            = r_idle;
    assign bus.done            = r_done;
    assign bus.aborted         = r_aborted;
    assign bus.err             = r_err;
    assign bus.finished_count  = r_finished;
    assign bus.core_start      = r_cs;
    assign bus.core_kernel_idx = r_kidx;

endmodule

// File: doc/cnn_kernel_seq.md
# cnn_kernel_seq

Parametrised kernel-pass sequencer that sits between the system controller and the single-pass convolution core (start/idle/finish handshake). It runs a run-time-selected number of kernel passes starting at a programmable kernel index, and lets up to `MAX_OUTSTANDING` passes overlap. It also supports abort, an acknowledge watchdog and sticky error reporting. It generalises the fixed 64-pass, one-in-flight controller used today.

## Interface
- `MAX_KERNELS`, 64, kernel slots addressable by the core; power of two.
- `KIDX_W`, $clog2(MAX_KERNELS), kernel index width.
- `CNT_W`, KIDX_W+1, pass-count width.
- `MAX_OUTSTANDING`, 2, passes started but not yet finished (1..3).
- `ACK_TIMEOUT`, 16, cycles allowed for core to drop `core_idle` after `core_start`.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: run request; sampled only in IDLE.
- `cfg_num_kernels` in CNT_W: passes to run; valid range 1..MAX_KERNELS; sampled with `start`.
- `cfg_kernel_base` in KIDX_W: first kernel index; sampled with `start`.
- `abort` in 1: level; stops issuing new passes.
- `idle` out 1: sequencer in IDLE.
- `done` out 1: one-cycle pulse at end of run (normal or aborted).
- `aborted` out 1: valid with `done`; 1 if the run was cut short.
- `err` out 1: sticky error; cleared by next accepted `start`.
- `finished_count` out CNT_W: passes completed in the current/last run.
- `core_start` out 1: one-cycle start pulse to core.
- `core_kernel_idx` out KIDX_W: kernel index, stable from `core_start` until next `core_start`.
- `core_idle` in 1: core idle.
- `core_finish` in 1: core pass-complete pulse.

## Operation
- States: IDLE, ISSUE, ACK, GAP, DRAIN.
- IDLE: `start`=1 with cfg in range -> latch cfg; clear counters and `err`; go ISSUE.
  - Out-of-range cfg (0 or >MAX_KERNELS) -> no run; `err`=1, `done`+`aborted` pulse next cycle; stay IDLE.
- ISSUE: `core_start`=1 for exactly this one cycle.
  - `core_kernel_idx` = (base + issued) mod MAX_KERNELS, wraps silently.
  - `issued`++; go ACK.
- ACK: wait for `core_idle`=0, then:
  - `issued`==num or `abort` -> DRAIN;
  - else -> GAP.
  - If watchdog reaches ACK_TIMEOUT: set `err`, treat as aborted, go DRAIN.
- GAP: `abort` -> DRAIN; else go ISSUE when `core_idle`=1 and (issued − finished) < MAX_OUTSTANDING.
- DRAIN: wait until finished == issued, or watchdog-abort with no ack; then pulse `done` and go IDLE.
- `core_finish` is counted in every non-IDLE state, including the same cycle as an issue.
  - A finish when outstanding==0, or in IDLE, is ignored and sets `err`.
- `aborted` = abort seen, or timeout; latched and held until next `start`.
- Counter widths are CNT_W; arithmetic never overflows because issued ≤ num ≤ MAX_KERNELS.

## Timing
- Reset values:
  - `idle`=1; all other outputs (`done`, `aborted`, `err`, `finished_count`, `core_start`, `core_kernel_idx`) = 0.
  - State IDLE; internal counters 0.
- All outputs are registered.
- `start` at cycle t -> `core_start` high at t+1; `idle` low at t+1.
- Minimum spacing between consecutive `core_start` pulses is 3 cycles (ISSUE, ACK, GAP).
- `done` rises the cycle after the last counted `core_finish`; `idle` rises the same cycle.
- `abort` in the same cycle as an ACK exit: abort wins, no further ISSUE.
- `start` outside IDLE: ignored.
- `rst` mid-run: immediate return to reset values; the core is not signalled, and the controller must also reset it.

## Structure
- Shared package `cnn_pkg`: state encoding enum, `MAX_KERNELS`/`MAX_OUTSTANDING` defaults.
- Single sub-module `cnn_ack_watchdog`: loadable down-counter with `expired` output, cleared on ISSUE.

## Test plan
- num=64, base=0, core acks in 2 cycles and finishes 40 cycles after ack -> indices 0..63 in order, `finished_count`=64, single `done`, `aborted`=0, `err`=0.
- num=5, base=62, MAX_OUTSTANDING=2 -> indices 62,63,0,1,2; never more than 2 unfinished passes.
- Core never drops `core_idle` after first `core_start` -> `err`=1 after 16 cycles; `done`+`aborted` pulse; `idle`=1.
- num=10, `abort` asserted after 3rd ack -> no 4th `core_start`; `done` after 3rd finish; `finished_count`=3, `aborted`=1.
- cfg_num_kernels=0 and 65 -> no `core_start`; `err`=1, `done`+`aborted` pulse.
  - A subsequent valid `start` clears `err`.
- `rst` pulse mid-run, then spurious `core_finish` in IDLE -> outputs at reset values, then `err`=1 and no `done`.
